// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction, direction and sequencer state types
package instr_pkg;
  typedef enum logic [1:0] {DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef struct packed {
    logic [1:0] torque;
    dir_t       dir;
  } instr_t;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: strobes + instr_in from the controller (master), drive/status outputs from the sequencer (slave)
interface instruction_sequencer_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic          save;
  logic          execute;
  logic          clear;
  logic          delete;
  logic [3:0]    instr_in;
  logic          drive_en;
  logic [1:0]    drive_dir;
  logic [1:0]    drive_torque;
  logic [AW-1:0] step_idx;
  logic [AW:0]   count;
  logic          busy;
  logic          full;
  logic          empty;
  logic          done;
  modport master (
    output save, execute, clear, delete, instr_in,
    input  drive_en, drive_dir, drive_torque, step_idx, count, busy, full, empty, done
  );
  modport slave (
    input  save, execute, clear, delete, instr_in,
    output drive_en, drive_dir, drive_torque, step_idx, count, busy, full, empty, done
  );
endinterface

// File: rtl/step_timer.sv
// step_timer: counts 0..STEP_CYCLES-1 while en, clr/rst zero it, tc marks the last cycle of a step (ports clk, rst, clr, en, tc)
module step_timer #(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);
  logic [TW-1:0] cnt;
  assign tc = en && cnt == LAST;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: records up to DEPTH instructions and replays each for STEP_CYCLES (ports CLOCK_50, reset, bus slave)
module instruction_sequencer
  import instr_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 50_000_000
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  instruction_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  instr_t        mem [DEPTH];
  state_t        state;
  logic [AW:0]   count;
  logic [AW-1:0] step;
  logic          en_q, busy_q, done_q, tc, last;
  logic [1:0]    dir_q, tq_q;
  assign last = ({1'b0, step} + 1'b1) == count;
  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk (CLOCK_50),
    .rst (reset),
    .clr (bus.clear || state != HOLD),
    .en  (state == HOLD),
    .tc  (tc)
  );
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      step   <= '0;
      en_q   <= 1'b0;
      dir_q  <= '0;
      tq_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        state  <= IDLE;
        count  <= '0;
        step   <= '0;
        en_q   <= 1'b0;
        dir_q  <= '0;
        tq_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE:
            if (bus.execute && count != '0) begin
              state         <= HOLD;
              step          <= '0;
              en_q          <= 1'b1;
              {tq_q, dir_q} <= mem[0];
              busy_q        <= 1'b1;
            end else if (bus.save && !bus.full) begin
              mem[count[AW-1:0]] <= instr_t'(bus.instr_in);
              count              <= count + 1'b1;
            end else if (bus.delete && count != '0) begin
              count <= count - 1'b1;
            end
          HOLD:
            if (tc) begin
              if (last) begin
                state  <= DONE;
                en_q   <= 1'b0;
                dir_q  <= '0;
                tq_q   <= '0;
                done_q <= 1'b1;
              end else begin
                step          <= step + 1'b1;
                {tq_q, dir_q} <= mem[step + 1'b1];
              end
            end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            step   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.drive_en     = en_q;
  assign bus.drive_dir    = dir_q;
  assign bus.drive_torque = tq_q;
  assign bus.step_idx     = step;
  assign bus.count        = count;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.full         = count == (AW+1)'(DEPTH);
  assign bus.empty        = count == '0;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed checks of record, playback, clear, reset and strobe priority with DEPTH=4, STEP_CYCLES=4
module tb_instruction_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  instruction_sequencer_if #(.DEPTH(4)) bus ();
  instruction_sequencer #(.DEPTH(4), .STEP_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_buf [4];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic e, input logic c, input logic d, input logic [3:0] ins);
    bus.save = s;
    bus.execute = e;
    bus.clear = c;
    bus.delete = d;
    bus.instr_in = ins;
    @(posedge clk);
    #1;
    bus.save = 1'b0;
    bus.execute = 1'b0;
    bus.clear = 1'b0;
    bus.delete = 1'b0;
    bus.instr_in = 4'h0;
  endtask
  task automatic idle_chk(input string tag, input int cnt);
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({tag, "_full"}, 32'(bus.full), 32'(cnt == 4));
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_en"}, 32'(bus.drive_en), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask
  // entered right after the execute edge; ends back in IDLE after the done cycle
  task automatic play(input int n, input bit inj);
    for (int i = 0; i < 4 * n; i++) begin
      chk("play_en", 32'(bus.drive_en), 1);
      chk("play_dir", 32'(bus.drive_dir), 32'(exp_buf[i/4][1:0]));
      chk("play_tq", 32'(bus.drive_torque), 32'(exp_buf[i/4][3:2]));
      chk("play_step", 32'(bus.step_idx), 32'(i / 4));
      chk("play_busy", 32'(bus.busy), 1);
      chk("play_done", 32'(bus.done), 0);
      cyc(inj && i == 2, inj && i == 2, 1'b0, inj && i == 2, 4'hF);
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_en", 32'(bus.drive_en), 0);
    chk("done_dir", 32'(bus.drive_dir), 0);
    chk("done_tq", 32'(bus.drive_torque), 0);
    chk("done_busy", 32'(bus.busy), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("post_done", 32'(bus.done), 0);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_step", 32'(bus.step_idx), 0);
  endtask
  initial begin
    bus.save = 1'b0;
    bus.execute = 1'b0;
    bus.clear = 1'b0;
    bus.delete = 1'b0;
    bus.instr_in = 4'h0;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
    chk("rst_dir", 32'(bus.drive_dir), 0);
    chk("rst_tq", 32'(bus.drive_torque), 0);
    chk("rst_step", 32'(bus.step_idx), 0);
    idle_chk("rst", 0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    idle_chk("save1", 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h8);
    idle_chk("save3", 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'hE);
    idle_chk("save4", 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    idle_chk("save5_full", 4);
    exp_buf = '{4'h0, 4'h4, 4'h8, 4'hE};
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    play(4, 1'b0);
    idle_chk("after_play4", 4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    idle_chk("clear_idle", 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    idle_chk("delete_empty", 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    idle_chk("exec_empty", 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'hB);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    idle_chk("delete1", 2);
    exp_buf = '{4'hB, 4'h5, 4'h0, 4'h0};
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    play(2, 1'b1);
    idle_chk("hold_ignore", 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
    idle_chk("save_delete", 3);
    exp_buf = '{4'hB, 4'h5, 4'h7, 4'h0};
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    play(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("mid_step", 32'(bus.step_idx), 1);
    chk("mid_dir", 32'(bus.drive_dir), 1);
    chk("mid_en", 32'(bus.drive_en), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    idle_chk("clear_play", 0);
    chk("clear_dir", 32'(bus.drive_dir), 0);
    chk("clear_tq", 32'(bus.drive_torque), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("clear_no_done", 32'(bus.done), 0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    idle_chk("exec_after_clear", 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("pre_reset_en", 32'(bus.drive_en), 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    idle_chk("mid_reset", 0);
    chk("mid_reset_dir", 32'(bus.drive_dir), 0);
    chk("mid_reset_tq", 32'(bus.drive_torque), 0);
    chk("mid_reset_step", 32'(bus.step_idx), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      idle_chk("post_reset", 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
